// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
//
// Purpose: FSM state encoding, data word width and read/write encoding used by
//          data_mem_responder and its testbench.
// Ports:   none (package).
package dmem_pkg;

    localparam int WORD_W = 32;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_sram_array.sv
// rtl/dmem_sram_array.sv - single-port synchronous data SRAM with registered read
//
// Purpose: 2^ADDR_W x WORD_W storage. Writes commit on the clock edge when
//          we_i is high. Reads load rdata_o on the edge when re_i is high; the
//          read register holds its value otherwise. Only the read register is
//          reset, never the array contents.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   synchronous active-low reset (read register only)
//   we_i     in   write enable
//   re_i     in   read enable
//   addr_i   in   word index
//   wdata_i  in   write data
//   rdata_o  out  registered read data
module dmem_sram_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data-memory target for the CPU memory stage
//
// Purpose: accepts one word read or write per request in IDLE, counts LATENCY
//          edges in BUSY, performs the SRAM access on the final edge together
//          with a one-cycle ready pulse, then spends one DONE cycle before
//          accepting again. All outputs are registered.
// Optional feature: DATA_MEM_ALIGN_CHECK_EN - misaligned accesses are
//          suppressed and flagged on oAlignErr alongside oDataMemReady.
// Ports:
//   iClk           in   clock
//   iRst_n         in   synchronous active-low reset
//   iDataMemValid  in   request present
//   iDataMemRW     in   1 = write, 0 = read
//   iDataMemAddr   in   byte address
//   iDataMemData   in   write data
//   oDataMemData   out  last read result
//   oDataMemReady  out  completion pulse
//   oAlignErr      out  misaligned-access flag (0 unless the option is built in)
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iDataMemValid,
    input  logic        iDataMemRW,
    input  logic [31:0] iDataMemAddr,
    input  logic [31:0] iDataMemData,
    output logic [31:0] oDataMemData,
    output logic        oDataMemReady,
    output logic        oAlignErr
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              access;
    logic              access_ok;
    logic              sram_we;
    logic              sram_re;

    // Upper address bits wrap the index; the low two bits only matter to the
    // optional alignment check.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iDataMemAddr[31:ADDR_W+2], iDataMemAddr[1:0]};

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic mis_q, mis_d;
    logic err_q, err_d;

    assign access_ok = !mis_q;
    assign err_d     = access && mis_q;
    assign oAlignErr = err_q;
`else
    assign access_ok = 1'b1;
    assign oAlignErr = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        access  = 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (iDataMemValid) begin
                    rw_d    = iDataMemRW;
                    idx_d   = iDataMemAddr[ADDR_W+1:2];
                    wdata_d = iDataMemData;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
`ifdef DATA_MEM_ALIGN_CHECK_EN
                    mis_d   = (iDataMemAddr[1:0] != 2'b00);
`endif
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset on the access edge must abandon the write, so the enables are
    // qualified with the reset input rather than relying on state alone.
    assign sram_we = access && access_ok && (rw_q == MEM_WRITE) && iRst_n;
    assign sram_re = access && access_ok && (rw_q == MEM_READ)  && iRst_n;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= MEM_READ;
            idx_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            mis_q   <= mis_d;
            err_q   <= err_d;
`endif
        end
    end

    // The SRAM read register doubles as the output data register, so read
    // data appears on the same edge that raises ready and holds until the
    // next successful read.
    dmem_sram_array #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk_i   (iClk),
        .rst_ni  (iRst_n),
        .we_i    (sram_we),
        .re_i    (sram_re),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (oDataMemData)
    );

    assign oDataMemReady = ready_q;

endmodule
